// File: rtl/multdiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_seq_pkg
// Description : Shared definitions for the multiply/divide sequencer.
//               Contents: FSM state encoding, rstatus exception codes, the
//               ALU op codes that identify mul/div in execute, and a helper
//               that maps (exception, op kind) to an rstatus code.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   localparam logic [2:0] STATUS_MUL = 3'd4;
   localparam logic [2:0] STATUS_DIV = 3'd5;

   localparam logic [4:0] ALUOP_MUL  = 5'b00110;
   localparam logic [4:0] ALUOP_DIV  = 5'b00111;

   // rstatus is only non-zero when the operation raised an exception.
   function automatic logic [2:0] status_code(input logic exc, input logic is_div);
      if (!exc) begin
         return 3'd0;
      end
      return is_div ? STATUS_DIV : STATUS_MUL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_watchdog_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_watchdog_counter
// Description : Watchdog for the multiply/divide WAIT state. Counts enabled
//               cycles from zero and raises a terminal-count flag once the
//               count reaches TIMEOUT_CYCLES-1, where it then holds.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               i_clear   - synchronous clear to zero (priority over enable)
//               i_enable  - advance the count this cycle
//               o_tc      - count == TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module md_watchdog_counter #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);

   localparam int            CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] C_TERMINAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_tc) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tc = (r_count == C_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Execute-stage controller for the iterative multiply/divide
//               unit. Detects mul/div in execute, captures operands, issues a
//               one-cycle start pulse, stalls the pipeline until the unit is
//               ready (or the watchdog expires), then presents the result and
//               an rstatus code for one cycle.
// Config      : MULTDIV_DIV0_BYPASS_EN - when defined, divide-by-zero is
//               resolved locally without launching the unit.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               ex_is_mult, ex_is_div, ex_kill - execute-stage instruction info
//               ex_operand_a/b                 - execute-stage operands
//               md_result, md_exception,
//               md_ready                       - unit response
//               md_ctrl_mult/div               - one-cycle start pulses
//               md_operand_a/b                 - registered operands to unit
//               stall                          - pipeline freeze
//               res_valid, res_data,
//               res_exception, res_status      - result presentation
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
   import multdiv_seq_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_is_mult,
   input  logic             ex_is_div,
   input  logic             ex_kill,
   input  logic [WIDTH-1:0] ex_operand_a,
   input  logic [WIDTH-1:0] ex_operand_b,
   input  logic [WIDTH-1:0] md_result,
   input  logic             md_exception,
   input  logic             md_ready,
   output logic             md_ctrl_mult,
   output logic             md_ctrl_div,
   output logic [WIDTH-1:0] md_operand_a,
   output logic [WIDTH-1:0] md_operand_b,
   output logic             stall,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_exception,
   output logic [WIDTH-1:0] res_status
);

   md_state_e        r_state;
   md_state_e        w_next_state;
   logic             r_op_div;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_exc;

   logic             w_detect;
   logic             w_detect_div;
   logic             w_bypass;
   logic             w_wd_clear;
   logic             w_wd_enable;
   logic             w_wd_tc;
   logic             w_timeout;

   // Gated by rst_n so stall stays low while reset is held.
   assign w_detect     = rst_n & (ex_is_mult | ex_is_div) & ~ex_kill;
   // Mult wins when both decode flags are set.
   assign w_detect_div = ex_is_div & ~ex_is_mult;

`ifdef MULTDIV_DIV0_BYPASS_EN
   assign w_bypass = w_detect & w_detect_div & (ex_operand_b == '0);
`else
   assign w_bypass = 1'b0;
`endif

   assign w_timeout = (r_state == ST_WAIT) & ~md_ready & w_wd_tc;

   md_watchdog_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_wd_clear),
      .i_enable (w_wd_enable),
      .o_tc     (w_wd_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      md_ctrl_mult = 1'b0;
      md_ctrl_div  = 1'b0;
      w_wd_clear   = 1'b0;
      w_wd_enable  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            stall = w_detect;
            if (w_bypass) begin
               w_next_state = ST_DONE;
            end else if (w_detect) begin
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            stall        = 1'b1;
            md_ctrl_mult = ~r_op_div;
            md_ctrl_div  = r_op_div;
            w_wd_clear   = 1'b1;
            // An early ready from the unit is accepted straight away.
            w_next_state = md_ready ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            stall = 1'b1;
            if (md_ready || w_wd_tc) begin
               w_next_state = ST_DONE;
            end else begin
               w_wd_enable = 1'b1;
            end
         end
         ST_DONE: begin
            // Stall released: the pipeline retires the mul/div this cycle.
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_div   <= 1'b0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_res_data <= '0;
         r_res_exc  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_detect) begin
            r_op_div <= w_detect_div;
            r_op_a   <= ex_operand_a;
            r_op_b   <= ex_operand_b;
         end
         if (w_bypass && (r_state == ST_IDLE)) begin
            r_res_data <= '0;
            r_res_exc  <= 1'b1;
         end else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && md_ready) begin
            r_res_exc  <= md_exception;
            r_res_data <= md_exception ? '0 : md_result;
         end else if (w_timeout) begin
            r_res_exc  <= 1'b1;
            r_res_data <= '0;
         end
      end
   end

   assign md_operand_a  = r_op_a;
   assign md_operand_b  = r_op_b;
   assign res_valid     = (r_state == ST_DONE);
   assign res_data      = res_valid ? r_res_data : '0;
   assign res_exception = res_valid & r_res_exc;
   assign res_status    = res_valid ? WIDTH'(status_code(r_res_exc, r_op_div)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Self-checking bench for multdiv_sequencer. Directed scenarios
//               plus randomized operations checked against a cycle-budget and
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

   localparam int W  = 32;
   localparam int TO = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_is_mult, ex_is_div, ex_kill;
   logic [W-1:0]  ex_operand_a, ex_operand_b;
   logic [W-1:0]  md_result;
   logic          md_exception, md_ready;
   logic          md_ctrl_mult, md_ctrl_div;
   logic [W-1:0]  md_operand_a, md_operand_b;
   logic          stall, res_valid, res_exception;
   logic [W-1:0]  res_data, res_status;

   int n_cmp  = 0;
   int n_fail = 0;

   multdiv_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_is_mult(ex_is_mult), .ex_is_div(ex_is_div), .ex_kill(ex_kill),
      .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
      .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
      .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
      .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
      .stall(stall), .res_valid(res_valid), .res_data(res_data),
      .res_exception(res_exception), .res_status(res_status)
   );

   always #5 clk = ~clk;

   // Arithmetic the unit would compute (mult wins when both flags set).
   function automatic logic [W-1:0] arith(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!is_div) return a * b;
      if (b == 0)  return '1;
      return a / b;
   endfunction

   // Drives one execute-stage mul/div and models the unit: ready is raised
   // ready_after cycles after the observed start pulse (0 = same cycle as the
   // pulse, negative = never). Returns observations only; callers compare.
   task automatic run_op(input logic mul, input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic kill, input int ready_after, input logic exc, input int limit,
                         output int stall_cnt, output int n_mp, output int n_dp, output int pulse_cyc,
                         output int done_cyc, output logic [W-1:0] rdata, output logic rexc,
                         output logic [W-1:0] rstat, output logic held);
      logic is_div;
      is_div    = div & ~mul;
      stall_cnt = 0; n_mp = 0; n_dp = 0; pulse_cyc = -1; done_cyc = -1;
      rdata = 'x; rexc = 1'bx; rstat = 'x; held = 1'b1;
      ex_is_mult = mul; ex_is_div = div; ex_kill = kill; ex_operand_a = a; ex_operand_b = b;
      for (int cyc = 0; cyc < limit; cyc++) begin
         md_ready     = (pulse_cyc >= 0) && (ready_after > 0) && (cyc == pulse_cyc + ready_after);
         md_exception = md_ready ? exc : 1'($urandom_range(0, 1));
         md_result    = (md_ready && !exc) ? arith(is_div, a, b) : $urandom();
         @(negedge clk);
         if (stall) stall_cnt++;
         if (md_ctrl_mult) n_mp++;
         if (md_ctrl_div) n_dp++;
         if ((md_ctrl_mult || md_ctrl_div) && pulse_cyc < 0) begin
            pulse_cyc = cyc;
            if (ready_after == 0) begin
               md_ready     = 1'b1;
               md_exception = exc;
               md_result    = exc ? $urandom() : arith(is_div, a, b);
            end
         end
         if (!kill && cyc >= 1 && (md_operand_a !== a || md_operand_b !== b)) held = 1'b0;
         if (res_valid) begin
            done_cyc = cyc; rdata = res_data; rexc = res_exception; rstat = res_status;
         end
         @(posedge clk); #1;
         if (done_cyc >= 0) break;
      end
      ex_is_mult = 0; ex_is_div = 0; ex_kill = 0; md_ready = 0; md_exception = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_is_mult = 1; ex_is_div = 0; ex_kill = 0; ex_operand_a = 9; ex_operand_b = 3;
      md_ready = 1; md_exception = 1; md_result = 32'hdead_beef;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({stall, res_valid, md_ctrl_mult, md_ctrl_div, res_exception} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl got=%b want=00000", {stall, res_valid, md_ctrl_mult, md_ctrl_div, res_exception});
      end
      n_cmp++;
      if ({md_operand_a, md_operand_b, res_data, res_status} !== '0) begin
         n_fail++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", md_operand_a, md_operand_b, res_data, res_status);
      end
      ex_is_mult = 0; md_ready = 0; md_exception = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      run_op(1, 0, 7, 6, 0, 32, 0, 80, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (mp !== 1 || dp !== 0 || pc !== 1) begin
         n_fail++; $display("FAIL mul_pulse got mult=%0d div=%0d at=%0d want 1/0 at 1", mp, dp, pc);
      end
      n_cmp++;
      if (sc !== 34 || dc !== 34) begin
         n_fail++; $display("FAIL mul_timing got stall=%0d done=%0d want 34/34", sc, dc);
      end
      n_cmp++;
      if (rd !== 42 || rs !== 0 || re !== 1'b0 || h !== 1'b1) begin
         n_fail++; $display("FAIL mul_result got data=%0d status=%0d exc=%b held=%b want 42/0/0/1", rd, rs, re, h);
      end
   endtask

   task automatic test_div();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      run_op(0, 1, 100, 7, 0, 32, 0, 80, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (mp !== 0 || dp !== 1 || pc !== 1 || dc !== 34) begin
         n_fail++; $display("FAIL div_pulse got mult=%0d div=%0d at=%0d done=%0d want 0/1/1/34", mp, dp, pc, dc);
      end
      n_cmp++;
      if (rd !== 14 || rs !== 0 || re !== 1'b0 || h !== 1'b1) begin
         n_fail++; $display("FAIL div_result got data=%0d status=%0d exc=%b held=%b want 14/0/0/1", rd, rs, re, h);
      end
   endtask

   task automatic test_timeout();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      run_op(1, 0, 123, 456, 0, -1, 0, 80, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (sc !== TO + 2 || dc !== TO + 2 || mp !== 1) begin
         n_fail++; $display("FAIL timeout_timing got stall=%0d done=%0d pulses=%0d want %0d/%0d/1", sc, dc, mp, TO + 2, TO + 2);
      end
      n_cmp++;
      if (rd !== 0 || re !== 1'b1 || rs !== 4) begin
         n_fail++; $display("FAIL timeout_result got data=%0d exc=%b status=%0d want 0/1/4", rd, re, rs);
      end
   endtask

   task automatic test_div_zero();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
`ifdef MULTDIV_DIV0_BYPASS_EN
      run_op(0, 1, 55, 0, 0, 3, 1, 20, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (dp !== 0 || sc !== 1 || dc !== 1) begin
         n_fail++; $display("FAIL div0_bypass got pulses=%0d stall=%0d done=%0d want 0/1/1", dp, sc, dc);
      end
`else
      run_op(0, 1, 55, 0, 0, 3, 1, 20, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (dp !== 1 || sc !== 5 || dc !== 5) begin
         n_fail++; $display("FAIL div0_launch got pulses=%0d stall=%0d done=%0d want 1/5/5", dp, sc, dc);
      end
`endif
      n_cmp++;
      if (rd !== 0 || re !== 1'b1 || rs !== 5) begin
         n_fail++; $display("FAIL div0_result got data=%0d exc=%b status=%0d want 0/1/5", rd, re, rs);
      end
   endtask

   task automatic test_early_ready();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      run_op(1, 0, 11, 13, 0, 0, 0, 20, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (sc !== 2 || dc !== 2 || mp !== 1 || rd !== 143) begin
         n_fail++; $display("FAIL early_ready got stall=%0d done=%0d pulses=%0d data=%0d want 2/2/1/143", sc, dc, mp, rd);
      end
   endtask

   task automatic test_back_to_back();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      int sc2, mp2, dp2, pc2, dc2; logic [W-1:0] rd2, rs2; logic re2, h2;
      int extra;
      run_op(1, 0, 3, 4, 0, 2, 0, 20, sc, mp, dp, pc, dc, rd, re, rs, h);
      run_op(1, 0, 5, 5, 0, 2, 0, 20, sc2, mp2, dp2, pc2, dc2, rd2, re2, rs2, h2);
      n_cmp++;
      if (rd !== 12 || rd2 !== 25) begin
         n_fail++; $display("FAIL b2b_data got %0d,%0d want 12,25", rd, rd2);
      end
      n_cmp++;
      if (mp !== 1 || mp2 !== 1 || pc2 !== 1 || dc !== 4 || dc2 !== 4) begin
         n_fail++; $display("FAIL b2b_timing got pulses %0d,%0d at2=%0d done %0d,%0d want 1,1 1 4,4", mp, mp2, pc2, dc, dc2);
      end
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (md_ctrl_mult || md_ctrl_div || stall || res_valid) extra++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (extra !== 0) begin
         n_fail++; $display("FAIL b2b_reissue got %0d active idle cycles want 0", extra);
      end
   endtask

   task automatic test_reset_mid_wait();
      int bad;
      ex_is_mult = 1; ex_is_div = 0; ex_kill = 0; ex_operand_a = 77; ex_operand_b = 88;
      md_ready = 0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({stall, res_valid, md_ctrl_mult, md_ctrl_div, res_exception} !== 5'b0 ||
          {md_operand_a, md_operand_b, res_data, res_status} !== '0) begin
         n_fail++; $display("FAIL midreset_outputs got stall=%b opa=%h opb=%h want all 0", stall, md_operand_a, md_operand_b);
      end
      ex_is_mult = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         md_ready = 1; md_exception = 0; md_result = $urandom();
         @(negedge clk);
         if (res_valid || stall || md_ctrl_mult || md_ctrl_div) bad++;
         @(posedge clk); #1;
      end
      md_ready = 0;
      n_cmp++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL midreset_late_ready got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_kill();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      run_op(1, 0, 2, 3, 1, 1, 0, 5, sc, mp, dp, pc, dc, rd, re, rs, h);
      n_cmp++;
      if (sc !== 0 || mp !== 0 || dp !== 0 || dc !== -1) begin
         n_fail++; $display("FAIL kill got stall=%0d pulses=%0d/%0d done=%0d want 0/0/0/-1", sc, mp, dp, dc);
      end
   endtask

   task automatic test_random();
      int sc, mp, dp, pc, dc; logic [W-1:0] rd, rs; logic re, h;
      logic m, d, exc, is_div, bypass, exp_exc;
      logic [W-1:0] a, b, exp_data, exp_stat;
      int k, exp_lat, exp_mp, exp_dp;
      for (int n = 0; n < 24; n++) begin
         m = 1'($urandom_range(0, 1));
         d = m ? 1'($urandom_range(0, 1)) : 1'b1;
         a = $urandom();
         b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 1000));
         k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 8));
         exc = ($urandom_range(0, 3) == 0);
         is_div = d & ~m;
         if (is_div && b == 0) exc = 1'b1;
`ifdef MULTDIV_DIV0_BYPASS_EN
         bypass = is_div && (b == 0);
`else
         bypass = 1'b0;
`endif
         run_op(m, d, a, b, 0, k, exc, 80, sc, mp, dp, pc, dc, rd, re, rs, h);
         if (bypass) begin
            exp_lat = 1; exp_mp = 0; exp_dp = 0; exp_exc = 1'b1;
         end else begin
            exp_lat = (k < 0) ? TO + 2 : k + 2;
            exp_mp = is_div ? 0 : 1; exp_dp = is_div ? 1 : 0;
            exp_exc = (k < 0) ? 1'b1 : exc;
         end
         exp_data = exp_exc ? '0 : arith(is_div, a, b);
         exp_stat = exp_exc ? (is_div ? 5 : 4) : 0;
         n_cmp++;
         if (sc !== exp_lat || dc !== exp_lat || mp !== exp_mp || dp !== exp_dp || h !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_timing got stall=%0d done=%0d pm=%0d pd=%0d held=%b want %0d/%0d/%0d/%0d/1",
                     n, sc, dc, mp, dp, h, exp_lat, exp_lat, exp_mp, exp_dp);
         end
         n_cmp++;
         if (rd !== exp_data || re !== exp_exc || rs !== exp_stat) begin
            n_fail++;
            $display("FAIL rand%0d_result got data=%h exc=%b status=%0d want %h/%b/%0d", n, rd, re, rs, exp_data, exp_exc, exp_stat);
         end
      end
   endtask

   initial begin
      ex_is_mult = 0; ex_is_div = 0; ex_kill = 0; ex_operand_a = 0; ex_operand_b = 0;
      md_result = 0; md_exception = 0; md_ready = 0; rst_n = 0;
      test_reset();
      test_mul();
      test_div();
      test_timeout();
      test_div_zero();
      test_early_ready();
      test_back_to_back();
      test_reset_mid_wait();
      test_kill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got no completion want finish");
      $fatal(1, "bench time limit reached");
   end

endmodule
`default_nettype wire
